// File: rtl/cla_addsub_pipe.sv
// -----------------------------------------------------------------------------
// cla_addsub_pipe
//   Pipelined carry-lookahead adder/subtractor with valid/ready flow control.
//   The carry network is a radix-2 prefix tree of depth log2(WIDTH). Each
//   level merges pairs of adjacent blocks, so no ripple chain is longer than
//   2 bits. STAGES sets the register depth, and that depth is also the latency:
//     1 : output register only
//     2 : input register + output register
//     3 : input register + register after the g/p tree (carries) + output reg
//
// Ports
//   clk, rst_n            clock; synchronous active-low reset
//   in_valid / in_ready   operand beat handshake
//   op                    00 ADD x+y, 01 SUB x-y, 10 ADC x+y+ci, 11 SBC x+~y+ci
//   ci                    carry-in for ADC/SBC
//   x, y                  operands
//   out_valid / out_ready result handshake
//   sum, cout, ovf, zero  result and flags (cout=1 means no borrow for SUB/SBC)
//
// Handshake: a beat moves on an edge where valid && ready are both high.
//   Valid is never withdrawn by this unit once asserted.
//   Result fields hold stable while out_valid && !out_ready.
//   in_ready depends combinationally on out_ready, because there is no skid buffer.
// -----------------------------------------------------------------------------
module cla_addsub_pipe #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic             ci,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int LEVELS = $clog2(WIDTH);
  localparam int LAST   = STAGES - 1;

  // ---------------------------------------------------------------------------
  // Stage occupancy and advance control.
  //   v[k]   : stage k holds a beat
  //   ld[k]  : stage k takes whatever is offered to it this cycle
  //   vin[k] : valid bit being offered to stage k
  // A stage may load when it is empty or when the stage after it is loading.
  // The chain starts at the output, which loads when it is empty or drained.
  // ---------------------------------------------------------------------------
  logic [STAGES-1:0] v;
  logic [STAGES-1:0] ld;
  logic [STAGES-1:0] vin;

  always_comb begin
    logic r;
    ld         = '0;
    r          = !v[LAST] || out_ready;
    ld[LAST]   = r;
    for (int k = STAGES - 2; k >= 0; k--) begin
      r     = !v[k] || r;
      ld[k] = r;
    end
  end

  always_comb begin
    vin    = '0;
    vin[0] = in_valid;
    for (int k = 1; k < STAGES; k++) begin
      vin[k] = v[k-1];
    end
  end

  assign in_ready  = ld[0];
  assign out_valid = v[LAST];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v <= '0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (ld[k]) v[k] <= vin[k];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Operand prep: subtraction inverts y, and carry-in comes from op/ci.
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] prep_y;
  logic             prep_cin;

  always_comb begin
    prep_y   = y;
    prep_cin = 1'b0;
    case (op)
      2'b00: begin prep_y = y;  prep_cin = 1'b0; end
      2'b01: begin prep_y = ~y; prep_cin = 1'b1; end
      2'b10: begin prep_y = y;  prep_cin = ci;   end
      2'b11: begin prep_y = ~y; prep_cin = ci;   end
      default: ;
    endcase
  end

  // Input register (STAGES >= 2). Data registers load only with a real beat,
  // so their contents stay put while the stage is empty.
  logic [WIDTH-1:0] a_x;
  logic [WIDTH-1:0] a_y;
  logic             a_cin;

  if (STAGES >= 2) begin : g_in_reg
    always_ff @(posedge clk) begin
      if (ld[0] && vin[0]) begin
        a_x   <= x;
        a_y   <= prep_y;
        a_cin <= prep_cin;
      end
    end
  end else begin : g_in_comb
    assign a_x   = x;
    assign a_y   = prep_y;
    assign a_cin = prep_cin;
  end

  // ---------------------------------------------------------------------------
  // Prefix tree. After level l, bit i holds the group generate/propagate for
  // bits [base..i], where base is i with its low (l+1) bits cleared.
  // At each level, bits in the upper half of a block absorb the group that ends
  // at the top of the lower half. That bit (j) is not written at this level,
  // so updating the vectors in place is safe.
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] t_p;
  logic [WIDTH:0]   t_c;

  always_comb begin
    logic [WIDTH-1:0] gg;
    logic [WIDTH-1:0] pp;
    int j;
    j   = 0;
    t_p = a_x ^ a_y;
    gg  = a_x & a_y;
    pp  = t_p;
    for (int l = 0; l < LEVELS; l++) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (((i >> l) & 1) == 1) begin
          j     = ((i >> l) << l) - 1;
          gg[i] = gg[i] | (pp[i] & gg[j]);
          pp[i] = pp[i] & pp[j];
        end
      end
    end
    // Fold carry-in into each prefix to get the carry into every bit.
    t_c[0] = a_cin;
    for (int i = 0; i < WIDTH; i++) begin
      t_c[i+1] = gg[i] | (pp[i] & a_cin);
    end
  end

  // Middle register (STAGES == 3): holds the bit propagates and resolved carries.
  logic [WIDTH-1:0] b_p;
  logic [WIDTH:0]   b_c;

  if (STAGES == 3) begin : g_mid_reg
    always_ff @(posedge clk) begin
      if (ld[1] && vin[1]) begin
        b_p <= t_p;
        b_c <= t_c;
      end
    end
  end else begin : g_mid_comb
    assign b_p = t_p;
    assign b_c = t_c;
  end

  // Output register. It holds its last value whenever no new beat arrives.
  logic [WIDTH-1:0] res_sum;
  assign res_sum = b_p ^ b_c[WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sum  <= '0;
      cout <= 1'b0;
      ovf  <= 1'b0;
      zero <= 1'b0;
    end else if (ld[LAST] && vin[LAST]) begin
      sum  <= res_sum;
      cout <= b_c[WIDTH];
      ovf  <= b_c[WIDTH] ^ b_c[WIDTH-1];
      zero <= (res_sum == '0);
    end
  end

endmodule
